// File: rtl/load_store_unit_pkg.sv
// Shared core definitions for the data-memory stage: FSM states, funct3
// width codes and the access-legality rule.
package load_store_unit_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Unsigned widths only make sense for loads; halfwords/words must be naturally aligned.
   function automatic logic lsu_legal(input logic we, input logic [2:0] f3,
                                      input logic [1:0] off);
      logic ok;
      case (f3)
         F3_B:    ok = 1'b1;
         F3_H:    ok = ~off[0];
         F3_W:    ok = (off == 2'b00);
         F3_BU:   ok = ~we;
         F3_HU:   ok = ~we & ~off[0];
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_store_unit_load_extender.sv
// Aligns the captured bus word to the addressed byte/halfword and applies
// sign or zero extension according to funct3.
module load_extender
   import load_store_unit_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] ext
);

   logic [31:0] shifted;
   assign shifted = word >> {offset, 3'b000};

   always_comb begin
      ext = shifted;
      case (funct3)
         F3_B:    ext = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    ext = {{16{shifted[15]}}, shifted[15:0]};
         F3_BU:   ext = {24'd0, shifted[7:0]};
         F3_HU:   ext = {16'd0, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: runs one valid/ready bus transfer per memory
// instruction, stalling the core until it completes or times out.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o,
   output logic        timeout_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_be_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ready_i
);

   // A zero-width counter is not legal, so a disabled timeout keeps one bit.
   localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   lsu_state_t    state;
   logic [CW-1:0] cnt;
   logic [1:0]    off_q;
   logic [2:0]    f3_q;
   logic          legal;
   logic [3:0]    be_d;
   logic [31:0]   wdata_d;
   logic [31:0]   load_ext;
   logic          tmo_hit;

   assign legal      = lsu_legal(we_i, funct3_i, addr_i[1:0]);
   assign misalign_o = req_i & ~legal;
   assign stall_o    = req_i & legal & (state != DONE);
   assign tmo_hit    = (TIMEOUT_CYCLES != 0) && (cnt == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      be_d    = 4'b1111;
      wdata_d = wdata_i;
      case (funct3_i)
         F3_B, F3_BU: begin
            be_d    = 4'b0001 << addr_i[1:0];
            wdata_d = {4{wdata_i[7:0]}};
         end
         F3_H, F3_HU: begin
            be_d    = 4'b0011 << {addr_i[1], 1'b0};
            wdata_d = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   load_extender u_load_extender (
      .word   (bus_rdata_i),
      .offset (off_q),
      .funct3 (f3_q),
      .ext    (load_ext)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         cnt         <= '0;
         off_q       <= '0;
         f3_q        <= '0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_be_o    <= '0;
         bus_wdata_o <= '0;
         rdata_o     <= '0;
         timeout_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_i && legal) begin
                  state       <= ACCESS;
                  cnt         <= '0;
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= we_i;
                  bus_addr_o  <= {addr_i[31:2], 2'b00};
                  bus_be_o    <= be_d;
                  bus_wdata_o <= wdata_d;
                  off_q       <= addr_i[1:0];
                  f3_q        <= funct3_i;
               end
            end
            ACCESS: begin
               if (bus_ready_i) begin
                  rdata_o   <= bus_we_o ? 32'd0 : load_ext;
                  cnt       <= '0;
                  bus_req_o <= 1'b0;
                  state     <= DONE;
               end else if (tmo_hit) begin
                  rdata_o   <= '0;
                  cnt       <= '0;
                  bus_req_o <= 1'b0;
                  timeout_o <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            DONE: begin
               timeout_o <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit: acts as core and memory, checking
// each access against a byte-level reference model.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   localparam int T = 4;

   logic        clk_i = 1'b0;
   logic        rst_i, req_i, we_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i, wdata_i, bus_rdata_i;
   logic        bus_ready_i;
   logic        stall_o, misalign_o, timeout_o, bus_req_o, bus_we_o;
   logic [31:0] rdata_o, bus_addr_o, bus_wdata_o;
   logic [3:0]  bus_be_o;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req_i),
      .we_i        (we_i),
      .funct3_i    (funct3_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .stall_o     (stall_o),
      .rdata_o     (rdata_o),
      .misalign_o  (misalign_o),
      .timeout_o   (timeout_o),
      .bus_req_o   (bus_req_o),
      .bus_we_o    (bus_we_o),
      .bus_addr_o  (bus_addr_o),
      .bus_be_o    (bus_be_o),
      .bus_wdata_o (bus_wdata_o),
      .bus_rdata_i (bus_rdata_i),
      .bus_ready_i (bus_ready_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int ref_size(input logic [2:0] f3);
      case (f3)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         3'd2:       return 4;
         default:    return 0;
      endcase
   endfunction

   function automatic bit ref_legal(input bit we, input logic [2:0] f3, input logic [1:0] off);
      int sz = ref_size(f3);
      if (sz == 0) return 0;
      if (we && f3[2]) return 0;
      return (int'(off) % sz) == 0;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] off,
                                            input logic [2:0] f3);
      int sz = ref_size(f3);
      logic [63:0] v, mask;
      v    = 64'(w) >> (8 * int'(off));
      mask = (64'd1 << (8 * sz)) - 64'd1;
      v    = v & mask;
      if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
      return v[31:0];
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [1:0] off);
      int sz = ref_size(f3);
      return 4'(((1 << sz) - 1) << int'(off));
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
      int sz = ref_size(f3);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
      return r;
   endfunction

   // Entered just after a rising edge; leaves just after the edge that ends the op.
   task automatic run_op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int delay, input logic [31:0] mem_word);
      int  exp_acc, stalls, accs;
      bit  to, done;
      req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = addr; wdata_i = wd;
      bus_ready_i = 1'b0; bus_rdata_i = $urandom();
      if (!ref_legal(we, f3, addr[1:0])) begin
         @(negedge clk_i);
         chk("mis_flag", misalign_o, 1);
         chk("mis_stall", stall_o, 0);
         chk("mis_busreq", bus_req_o, 0);
         @(negedge clk_i);
         chk("mis_busreq2", bus_req_o, 0);
         @(posedge clk_i); #1;
         req_i = 1'b0;
         return;
      end
      to      = (delay + 1 > T);
      exp_acc = to ? T : delay + 1;
      stalls  = 0; accs = 0; done = 0;
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         @(negedge clk_i);
         bus_ready_i = 1'b0;
         if (cyc == 0) chk("legal_flag", misalign_o, 0);
         if (!stall_o) begin
            done = 1;
            chk("stall_cycles", stalls, exp_acc + 1);
            chk("req_cycles", accs, exp_acc);
            chk("timeout", timeout_o, to);
            chk("rdata", rdata_o, (we || to) ? 32'd0 : ref_load(mem_word, addr[1:0], f3));
            chk("done_busreq", bus_req_o, 0);
         end else begin
            stalls++;
            if (bus_req_o) begin
               accs++;
               if (accs == 1) begin
                  chk("bus_we", bus_we_o, we);
                  chk("bus_addr", bus_addr_o, {addr[31:2], 2'b00});
                  chk("bus_be", bus_be_o, ref_be(f3, addr[1:0]));
                  if (we) chk("bus_wdata", bus_wdata_o, ref_wdata(f3, wd));
               end
               if (accs == delay + 1) begin
                  bus_ready_i = 1'b1;
                  bus_rdata_i = mem_word;
               end
            end
         end
      end
      if (!done) chk("done_reached", 0, 1);
      @(posedge clk_i); #1;
      bus_ready_i = 1'b0;
      req_i = 1'b0;
   endtask

   initial begin
      logic [2:0] f3;
      rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; funct3_i = '0; addr_i = '0;
      wdata_i = '0; bus_rdata_i = '0; bus_ready_i = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      chk("rst_stall", stall_o, 0);
      chk("rst_busreq", bus_req_o, 0);
      chk("rst_buswe", bus_we_o, 0);
      chk("rst_busaddr", bus_addr_o, 0);
      chk("rst_busbe", bus_be_o, 0);
      chk("rst_buswdata", bus_wdata_o, 0);
      chk("rst_rdata", rdata_o, 0);
      chk("rst_timeout", timeout_o, 0);
      chk("rst_misalign", misalign_o, 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;

      run_op(0, F3_W,  32'h0000_1000, 32'h0,        1,    32'hDEAD_BEEF);
      run_op(0, F3_B,  32'h0000_2003, 32'h0,        0,    32'h8012_3456);
      run_op(0, F3_BU, 32'h0000_2003, 32'h0,        0,    32'h8012_3456);
      run_op(1, F3_H,  32'h0000_3002, 32'h0000_ABCD, 0,   32'h1111_1111);
      run_op(0, F3_W,  32'h0000_1002, 32'h0,        0,    32'h0);
      run_op(0, F3_HU, 32'h0000_4002, 32'h0,        2,    32'hF00D_8001);
      run_op(0, F3_W,  32'h0000_5000, 32'h0,        1000, 32'h0);

      // Reset pulse while the bus request is outstanding.
      req_i = 1'b1; we_i = 1'b0; funct3_i = F3_W; addr_i = 32'h0000_6000;
      @(negedge clk_i);
      @(negedge clk_i);
      chk("pre_rst_busreq", bus_req_o, 1);
      rst_i = 1'b1; req_i = 1'b0;
      @(negedge clk_i);
      chk("mid_rst_busreq", bus_req_o, 0);
      chk("mid_rst_stall", stall_o, 0);
      chk("mid_rst_rdata", rdata_o, 0);
      chk("mid_rst_timeout", timeout_o, 0);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      run_op(0, F3_W, 32'h0000_7000, 32'h0, 0, 32'h1234_5678);

      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
         else case ($urandom_range(0, 4))
            0: f3 = F3_B;  1: f3 = F3_H;  2: f3 = F3_W;
            3: f3 = F3_BU; default: f3 = F3_HU;
         endcase
         run_op(bit'($urandom_range(0, 1)), f3, $urandom(), $urandom(),
                $urandom_range(0, 5), $urandom());
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk_i); #1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
